// File: rtl/matrix_pad_loader.sv
// Loads an r x c row-major element stream into a zero-padded 5x5 frame (slot i*5+j).
// Latency: in_ready one cycle after en; slot written on handshake edge; done the cycle after the last handshake.
// Backpressure: in_ready high only in LOAD; en low aborts or acknowledges. Clamp option: MATRIX_PAD_LOADER_CLAMP_EN.
module matrix_pad_loader #(
    parameter int                    DATA_WIDTH = 9,
    parameter logic [DATA_WIDTH-1:0] MAX_VAL    = 9'd255
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic [2:0]                 r,
    input  logic [2:0]                 c,
    input  logic                       in_valid,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       in_ready,
    output logic [25*DATA_WIDTH-1:0]   frame,
    output logic [4:0]                 count,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

`ifdef MATRIX_PAD_LOADER_CLAMP_EN
    localparam bit CLAMP_ON = 1'b1;
`else
    localparam bit CLAMP_ON = 1'b0;
`endif

    state_t                     state_q;
    logic [2:0]                 r_l_q;
    logic [2:0]                 c_l_q;
    logic [2:0]                 row_q;
    logic [2:0]                 col_q;
    logic [4:0]                 count_q;
    logic [25*DATA_WIDTH-1:0]   frame_q;
    logic                       in_ready_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       err_q;

    logic                       dims_ok;
    logic                       last_col;
    logic                       last_elem;
    logic [2:0]                 row_d;
    logic [2:0]                 col_d;
    logic [4:0]                 slot_idx;
    logic [DATA_WIDTH-1:0]      wr_dat;

    // Legal dimensions are 1..5 on both axes; 0, 6 and 7 are rejected.
    assign dims_ok   = (r >= 3'd1) && (r <= 3'd5) && (c >= 3'd1) && (c <= 3'd5);
    assign last_col  = (col_q == c_l_q - 3'd1);
    assign last_elem = last_col && (row_q == r_l_q - 3'd1);
    assign slot_idx  = 5'(row_q) * 5'd5 + 5'(col_q);
    // With clamping compiled out the comparison folds away and data passes straight through.
    assign wr_dat    = (CLAMP_ON && (in_data > MAX_VAL)) ? MAX_VAL : in_data;

    // Next write position: wrap column at the latched width and step the row.
    always_comb begin
        row_d = row_q;
        col_d = col_q + 3'd1;
        if (last_col) begin
            col_d = 3'd0;
            row_d = row_q + 3'd1;
        end
    end

    // Control FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            r_l_q      <= 3'd0;
            c_l_q      <= 3'd0;
            row_q      <= 3'd0;
            col_q      <= 3'd0;
            count_q    <= 5'd0;
            frame_q    <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!en) begin
                        err_q <= 1'b0;
                    end else if (dims_ok) begin
                        r_l_q      <= r;
                        c_l_q      <= c;
                        row_q      <= 3'd0;
                        col_q      <= 3'd0;
                        count_q    <= 5'd0;
                        frame_q    <= '0;
                        err_q      <= 1'b0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_LOAD;
                    end else begin
                        // Bad request: flag it and leave the previous frame untouched.
                        err_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (!en) begin
                        // Abort keeps the partial frame; a same-cycle element is dropped.
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else if (in_valid) begin
                        frame_q[int'(slot_idx)*DATA_WIDTH +: DATA_WIDTH] <= wr_dat;
                        count_q <= count_q + 5'd1;
                        row_q   <= row_d;
                        col_q   <= col_d;
                        if (last_elem) begin
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Frame is frozen until the downstream stage drops en.
                    if (!en) begin
                        done_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign count    = count_q;
    assign frame    = frame_q;

endmodule
